pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor.sv | 125 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_reset, waits for a stable lock, then releases sys_reset.
// Define PLL_LOCK_DEGLITCH_EN to ignore lock drops in RUN that last less than 4 cycles.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 27000,
    parameter int LOCK_STABLE      = 256,
    parameter int MAX_RETRY        = 7
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The floor of 4 keeps the deglitch filter count representable for tiny parameter sets.
    localparam int CNT_MAX = max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT), max2(LOCK_STABLE, 4));
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);
`ifdef PLL_LOCK_DEGLITCH_EN
    localparam logic [CNT_W-1:0] DGL_LAST     = CNT_W'(3);
`endif

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             lock_p0, lock_s;

    function automatic logic [3:0] retry_inc(input logic [3:0] r);
        return (r >= RETRY_MAX) ? r : r + 4'd1;
    endfunction

    // Stage 0/1: two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= pll_lock;
            lock_s  <= lock_p0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        retry_nxt = retry_cnt;
        unique case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_inc(retry_cnt);
                    state_nxt = (retry_nxt == RETRY_MAX) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                if (!lock_s)                 state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = RUN;
            end
            RUN: begin
`ifdef PLL_LOCK_DEGLITCH_EN
                // cnt doubles as the run of consecutive low lock samples
                if (lock_s)                cnt_nxt   = '0;
                else if (cnt == DGL_LAST)  state_nxt = RESET_PLL;
`else
                cnt_nxt = cnt;
                if (!lock_s) state_nxt = RESET_PLL;
`endif
            end
            FAIL: begin
                cnt_nxt = cnt;
            end
            default: begin
                state_nxt = RESET_PLL;
            end
        endcase
        if (state_nxt != state) cnt_nxt = '0;
        if (state_nxt == RUN)   retry_nxt = '0;
    end

    // Stage 2: state, counter and outputs registered together from the next state
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_reset <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
            sys_reset <= (state_nxt != RUN);
            locked    <= (state_nxt == RUN);
            fail      <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters; expected
// cycle positions are hand-derived from reset release (edge E1 is the first edge after release).
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset, sys_reset, locked, fail;
    logic [3:0] retry_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT    (20),
        .LOCK_STABLE     (8),
        .MAX_RETRY       (3)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_reset(sys_reset),
        .locked   (locked),
        .fail     (fail),
        .retry_cnt(retry_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic outs(input string tag, input int pr, input int sr, input int lk,
                        input int fl, input int rc);
        chk({tag, ".pll_reset"}, int'(pll_reset), pr);
        chk({tag, ".sys_reset"}, int'(sys_reset), sr);
        chk({tag, ".locked"},    int'(locked),    lk);
        chk({tag, ".fail"},      int'(fail),      fl);
        chk({tag, ".retry_cnt"}, int'(retry_cnt), rc);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        // Clean lock
        do_reset();
        outs("rst", 1, 1, 0, 0, 0);
        tick(3);
        chk("pulse_hold", int'(pll_reset), 1);
        tick(1);
        chk("pulse_end", int'(pll_reset), 0);
        tick(5);
        pll_lock = 1'b1;
        tick(10);
        outs("stable_hold", 0, 1, 0, 0, 0);
        tick(1);
        outs("run_entry", 0, 0, 1, 0, 0);

        // Lock loss in RUN
`ifndef PLL_LOCK_DEGLITCH_EN
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        outs("loss_sync", 0, 0, 1, 0, 0);
        tick(1);
        outs("loss_take", 1, 1, 0, 0, 0);
`else
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        tick(5);
        outs("dgl3_ignored", 0, 0, 1, 0, 0);
        pll_lock = 1'b0;
        tick(4);
        pll_lock = 1'b1;
        tick(1);
        outs("dgl4_filter", 0, 0, 1, 0, 0);
        tick(1);
        outs("dgl4_take", 1, 1, 0, 0, 0);
`endif
        tick(3);
        chk("loss_pulse_hold", int'(pll_reset), 1);
        tick(1);
        chk("loss_pulse_end", int'(pll_reset), 0);
        tick(8);
        chk("relock_stable", int'(sys_reset), 1);
        tick(1);
        outs("relock_run", 0, 0, 1, 0, 0);

        // Flicker in STABLE: one low sample restarts qualification
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(5);
        outs("flick_norun", 0, 1, 0, 0, 0);
        tick(5);
        chk("flick_late", int'(sys_reset), 1);
        tick(1);
        outs("flick_run", 0, 0, 1, 0, 0);

        // Lock rising on the timeout cycle wins; RUN entry clears retry_cnt
        do_reset();
        tick(23);
        outs("win_pre_to", 0, 1, 0, 0, 0);
        tick(1);
        outs("win_to1", 1, 1, 0, 0, 1);
        tick(21);
        pll_lock = 1'b1;
        tick(2);
        outs("win_before", 0, 1, 0, 0, 1);
        tick(1);
        outs("lock_wins", 0, 1, 0, 0, 1);
        tick(7);
        outs("win_stable", 0, 1, 0, 0, 1);
        tick(1);
        outs("win_run_clr", 0, 0, 1, 0, 0);

        // Async reset in RUN
        #3;
        reset = 1'b1;
        #1;
        outs("async_run", 1, 1, 0, 0, 0);
        tick(1);
        reset = 1'b0;

        // Async reset mid-STABLE
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        outs("mid_stable", 0, 1, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        outs("async_stable", 1, 1, 0, 0, 0);
        tick(1);
        reset = 1'b0;

        // Timeouts to FAIL
        pll_lock = 1'b0;
        do_reset();
        tick(24);
        outs("to1", 1, 1, 0, 0, 1);
        tick(23);
        outs("to2_pre", 0, 1, 0, 0, 1);
        tick(1);
        outs("to2", 1, 1, 0, 0, 2);
        tick(23);
        outs("to3_pre", 0, 1, 0, 0, 2);
        tick(1);
        outs("fail_entry", 1, 1, 0, 1, 3);
        pll_lock = 1'b1;
        tick(40);
        outs("fail_hold", 1, 1, 0, 1, 3);
        #3;
        reset = 1'b1;
        #1;
        outs("fail_async_rst", 1, 1, 0, 0, 0);
        tick(1);
        reset    = 1'b0;
        pll_lock = 1'b0;
        tick(3);
        chk("restart_pulse", int'(pll_reset), 1);
        tick(1);
        outs("restart_wait", 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
